// File: rtl/decode_stage.sv
// decode_stage: single-entry registered instruction decoder.
// Splits an instruction into opcode class, control command, register
// fields, ALU function and immediate; holds the decoded result until the
// consumer takes it, halts on a halt command, counts accepted instructions
// and keeps a sticky flag for illegal encodings.
module decode_stage #(
   parameter int INSTR_W = 16,
   parameter int REG_W   = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk_pi,
   input  logic               rst_n_pi,
   input  logic [INSTR_W-1:0] instruction_pi,
   input  logic               in_valid_pi,
   output logic               in_ready_po,
   input  logic               resume_pi,
   output logic               out_valid_po,
   input  logic               out_ready_pi,
   output logic [15:0]        class_po,
   output logic [3:0]         cmd_po,
   output logic [REG_W-1:0]   dest_po,
   output logic [REG_W-1:0]   src1_po,
   output logic [REG_W-1:0]   src2_po,
   output logic [2:0]         alu_func_po,
   output logic [INSTR_W-5:0] imm_po,
   output logic [CNT_W-1:0]   count_po,
   output logic               err_po
);

   // Field positions: opcode on top, then A, B, C register fields.
   localparam int IMM_W  = INSTR_W - 4;
   localparam int OPC_LSB = INSTR_W - 4;
   localparam int A_LSB  = OPC_LSB - REG_W;
   localparam int B_LSB  = A_LSB - REG_W;
   localparam int C_LSB  = B_LSB - REG_W;

   // One-hot class bit positions.
   localparam int CL_NOP       = 0;
   localparam int CL_ARITH_2OP = 1;
   localparam int CL_ARITH_1OP = 2;
   localparam int CL_MOVI_LO   = 3;
   localparam int CL_MOVI_HI   = 4;
   localparam int CL_ADDI      = 5;
   localparam int CL_SUBI      = 6;
   localparam int CL_LOAD      = 7;
   localparam int CL_STOR      = 8;
   localparam int CL_BEQ       = 9;
   localparam int CL_BGE       = 10;
   localparam int CL_BLE       = 11;
   localparam int CL_BC        = 12;
   localparam int CL_J         = 13;
   localparam int CL_CONTROL   = 14;
   localparam int CL_ILLEGAL   = 15;

   // Command flag positions inside cmd_po = {halt, rst, stb, stc}.
   localparam int CMD_STC_BIT  = 0;
   localparam int CMD_STB_BIT  = 1;
   localparam int CMD_RST_BIT  = 2;
   localparam int CMD_HALT_BIT = 3;

   // Alternating 1010... pattern over the command field (0xAAA at 16 bits).
   function automatic logic [IMM_W-1:0] f_alt_pattern();
      logic [IMM_W-1:0] v;
      v = '0;
      for (int i = 0; i < IMM_W; i++) begin
         v[i] = (i % 2) == 1;
      end
      return v;
   endfunction

   localparam logic [IMM_W-1:0] CMD_STC  = IMM_W'(1);
   localparam logic [IMM_W-1:0] CMD_STB  = IMM_W'(2);
   localparam logic [IMM_W-1:0] CMD_RST  = f_alt_pattern();
   localparam logic [IMM_W-1:0] CMD_HALT = '1;

   // Counter step that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [3:0]       w_opcode;
   logic [REG_W-1:0] w_fa;
   logic [REG_W-1:0] w_fb;
   logic [REG_W-1:0] w_fc;
   logic [IMM_W-1:0] w_cmd_field;
   logic [15:0]      w_class;
   logic [3:0]       w_cmd;
   logic [REG_W-1:0] w_src1;
   logic [REG_W-1:0] w_src2;
   logic             w_is_branch;
   logic             w_in_ready;
   logic             w_accept;

   logic             r_vld_p1;
   logic [15:0]      r_class_p1;
   logic [3:0]       r_cmd_p1;
   logic [REG_W-1:0] r_dest_p1;
   logic [REG_W-1:0] r_src1_p1;
   logic [REG_W-1:0] r_src2_p1;
   logic [2:0]       r_alu_p1;
   logic [IMM_W-1:0] r_imm_p1;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   assign w_opcode    = instruction_pi[INSTR_W-1:OPC_LSB];
   assign w_fa        = instruction_pi[A_LSB +: REG_W];
   assign w_fb        = instruction_pi[B_LSB +: REG_W];
   assign w_fc        = instruction_pi[C_LSB +: REG_W];
   assign w_cmd_field = instruction_pi[IMM_W-1:0];

   // Combinational decode of opcode and command field into class/command.
   always_comb begin
      w_class = '0;
      w_cmd   = '0;
      case (w_opcode)
         4'h0: w_class[CL_NOP]       = 1'b1;
         4'h1: w_class[CL_ARITH_2OP] = 1'b1;
         4'h2: w_class[CL_ARITH_1OP] = 1'b1;
         4'h3: begin
            if (w_fb[REG_W-1]) w_class[CL_MOVI_HI] = 1'b1;
            else               w_class[CL_MOVI_LO] = 1'b1;
         end
         4'h4: w_class[CL_ADDI] = 1'b1;
         4'h5: w_class[CL_SUBI] = 1'b1;
         4'h6: w_class[CL_LOAD] = 1'b1;
         4'h7: w_class[CL_STOR] = 1'b1;
         4'h8: w_class[CL_BEQ]  = 1'b1;
         4'h9: w_class[CL_BGE]  = 1'b1;
         4'hA: w_class[CL_BLE]  = 1'b1;
         4'hB: w_class[CL_BC]   = 1'b1;
         4'hC: w_class[CL_J]    = 1'b1;
         4'hF: begin
            if (w_cmd_field == CMD_STC) begin
               w_class[CL_CONTROL] = 1'b1;
               w_cmd[CMD_STC_BIT]  = 1'b1;
            end else if (w_cmd_field == CMD_STB) begin
               w_class[CL_CONTROL] = 1'b1;
               w_cmd[CMD_STB_BIT]  = 1'b1;
            end else if (w_cmd_field == CMD_RST) begin
               w_class[CL_CONTROL] = 1'b1;
               w_cmd[CMD_RST_BIT]  = 1'b1;
            end else if (w_cmd_field == CMD_HALT) begin
               w_class[CL_CONTROL] = 1'b1;
               w_cmd[CMD_HALT_BIT] = 1'b1;
            end else begin
               w_class[CL_ILLEGAL] = 1'b1;
            end
         end
         default: w_class[CL_ILLEGAL] = 1'b1;
      endcase
   end

   // Branches compare A against B; everything else reads B and C.
   always_comb begin
      w_is_branch = |w_class[CL_BC:CL_BEQ];
      if (w_is_branch) begin
         w_src1 = w_fa;
         w_src2 = w_fb;
      end else begin
         w_src1 = w_fb;
         w_src2 = w_fc;
      end
   end

   // Accept when running and the output slot is empty or draining now.
   assign w_in_ready = (r_state == S_RUN) & (~r_vld_p1 | out_ready_pi);
   assign w_accept   = in_valid_pi & w_in_ready;

   // State register for the run/halt control.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) r_state <= S_RUN;
      else           r_state <= w_state_nxt;
   end

   // Next state: halt takes effect at the edge that accepts it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_accept && w_cmd[CMD_HALT_BIT]) w_state_nxt = S_HALTED;
         end
         S_HALTED: begin
            if (resume_pi) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // ---- stage p1: decoded-instruction holding register ----
   // Load on accept, drop valid on a drain without refill, else hold.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         r_vld_p1   <= 1'b0;
         r_class_p1 <= '0;
         r_cmd_p1   <= '0;
         r_dest_p1  <= '0;
         r_src1_p1  <= '0;
         r_src2_p1  <= '0;
         r_alu_p1   <= '0;
         r_imm_p1   <= '0;
      end else if (w_accept) begin
         r_vld_p1   <= 1'b1;
         r_class_p1 <= w_class;
         r_cmd_p1   <= w_cmd;
         r_dest_p1  <= w_fa;
         r_src1_p1  <= w_src1;
         r_src2_p1  <= w_src2;
         r_alu_p1   <= instruction_pi[2:0];
         r_imm_p1   <= instruction_pi[IMM_W-1:0];
      end else if (out_ready_pi) begin
         r_vld_p1   <= 1'b0;
      end
   end

   // Accepted-instruction counter; an accepted rst command zeroes it.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         r_count <= '0;
      end else if (w_accept) begin
         if (w_cmd[CMD_RST_BIT]) r_count <= '0;
         else                    r_count <= f_sat_inc(r_count);
      end
   end

   // Sticky illegal flag, cleared only by reset or an accepted rst command.
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (w_class[CL_ILLEGAL])     r_err <= 1'b1;
         else if (w_cmd[CMD_RST_BIT]) r_err <= 1'b0;
      end
   end

   assign in_ready_po  = w_in_ready;
   assign out_valid_po = r_vld_p1;
   assign class_po     = r_class_p1;
   assign cmd_po       = r_cmd_p1;
   assign dest_po      = r_dest_p1;
   assign src1_po      = r_src1_p1;
   assign src2_po      = r_src2_p1;
   assign alu_func_po  = r_alu_p1;
   assign imm_po       = r_imm_p1;
   assign count_po     = r_count;
   assign err_po       = r_err;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_decode_stage;

   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic        clk_pi = 1'b0;
   logic        rst_n_pi;
   logic [15:0] instruction_pi;
   logic        in_valid_pi;
   logic        in_ready_po;
   logic        resume_pi;
   logic        out_valid_po;
   logic        out_ready_pi;
   logic [15:0] class_po;
   logic [3:0]  cmd_po;
   logic [2:0]  dest_po;
   logic [2:0]  src1_po;
   logic [2:0]  src2_po;
   logic [2:0]  alu_func_po;
   logic [11:0] imm_po;
   logic [CNT_W-1:0] count_po;
   logic        err_po;

   decode_stage #(.INSTR_W(16), .REG_W(3), .CNT_W(CNT_W)) dut (
      .clk_pi        (clk_pi),
      .rst_n_pi      (rst_n_pi),
      .instruction_pi(instruction_pi),
      .in_valid_pi   (in_valid_pi),
      .in_ready_po   (in_ready_po),
      .resume_pi     (resume_pi),
      .out_valid_po  (out_valid_po),
      .out_ready_pi  (out_ready_pi),
      .class_po      (class_po),
      .cmd_po        (cmd_po),
      .dest_po       (dest_po),
      .src1_po       (src1_po),
      .src2_po       (src2_po),
      .alu_func_po   (alu_func_po),
      .imm_po        (imm_po),
      .count_po      (count_po),
      .err_po        (err_po)
   );

   always #5 clk_pi = ~clk_pi;

   typedef struct packed {
      logic [15:0] cls;
      logic [3:0]  cmd;
      logic [2:0]  dest;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic [2:0]  alu;
      logic [11:0] imm;
   } exp_t;

   int   n_chk = 0;
   int   n_err = 0;

   // Reference model state
   logic m_valid;
   exp_t m_exp;
   int   m_count;
   logic m_err;
   logic m_halted;

   logic [2:0] q_deliv[$];

   // Decode rules evaluated with plain integer arithmetic on the word.
   function automatic exp_t ref_decode(input logic [15:0] ins);
      exp_t e;
      int x, op, a, b, c, low, idx;
      x   = ins;
      op  = x / 4096;
      a   = (x / 512) % 8;
      b   = (x / 64) % 8;
      c   = (x / 8) % 8;
      low = x % 4096;
      if (op <= 2)                 idx = op;
      else if (op == 3)            idx = (b >= 4) ? 4 : 3;
      else if (op <= 12)           idx = op + 1;
      else if (op == 15 && (low == 'h001 || low == 'h002 || low == 'hAAA || low == 'hFFF))
                                   idx = 14;
      else                         idx = 15;
      e.cls = 16'd1 << idx;
      e.cmd = 4'd0;
      if (idx == 14) begin
         if (low == 'h001)      e.cmd = 4'b0001;
         else if (low == 'h002) e.cmd = 4'b0010;
         else if (low == 'hAAA) e.cmd = 4'b0100;
         else                   e.cmd = 4'b1000;
      end
      e.dest = 3'(a);
      if (idx >= 9 && idx <= 12) begin
         e.s1 = 3'(a);
         e.s2 = 3'(b);
      end else begin
         e.s1 = 3'(b);
         e.s2 = 3'(c);
      end
      e.alu = 3'(x % 8);
      e.imm = 12'(low);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_count  = 0;
      m_err    = 1'b0;
      m_halted = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vld"},   32'(out_valid_po), 32'd0);
      chk({tag, "_class"}, 32'(class_po),     32'd0);
      chk({tag, "_cmd"},   32'(cmd_po),       32'd0);
      chk({tag, "_dest"},  32'(dest_po),      32'd0);
      chk({tag, "_src1"},  32'(src1_po),      32'd0);
      chk({tag, "_src2"},  32'(src2_po),      32'd0);
      chk({tag, "_alu"},   32'(alu_func_po),  32'd0);
      chk({tag, "_imm"},   32'(imm_po),       32'd0);
      chk({tag, "_count"}, 32'(count_po),     32'd0);
      chk({tag, "_err"},   32'(err_po),       32'd0);
   endtask

   task automatic chk_outputs();
      chk("out_valid", 32'(out_valid_po), 32'(m_valid));
      chk("count",     32'(count_po),     32'(m_count));
      chk("err",       32'(err_po),       32'(m_err));
      if (m_valid) begin
         chk("class", 32'(class_po),    32'(m_exp.cls));
         chk("cmd",   32'(cmd_po),      32'(m_exp.cmd));
         chk("dest",  32'(dest_po),     32'(m_exp.dest));
         chk("src1",  32'(src1_po),     32'(m_exp.s1));
         chk("src2",  32'(src2_po),     32'(m_exp.s2));
         chk("alu",   32'(alu_func_po), 32'(m_exp.alu));
         chk("imm",   32'(imm_po),      32'(m_exp.imm));
      end
   endtask

   // One clock cycle: entered and left 1 time unit after a rising edge.
   task automatic step(input logic v, input logic [15:0] ins, input logic ordy, input logic res);
      logic exp_rdy, acc;
      exp_t e;
      in_valid_pi    = v;
      instruction_pi = ins;
      out_ready_pi   = ordy;
      resume_pi      = res;
      @(negedge clk_pi);
      exp_rdy = !m_halted && (!m_valid || ordy);
      chk("in_ready", 32'(in_ready_po), 32'(exp_rdy));
      if (out_valid_po === 1'b1 && ordy) q_deliv.push_back(dest_po);
      acc = v && exp_rdy;
      @(posedge clk_pi);
      #1;
      if (m_halted && res) m_halted = 1'b0;
      if (acc) begin
         e       = ref_decode(ins);
         m_valid = 1'b1;
         m_exp   = e;
         if (e.cmd == 4'b0100)      m_count = 0;
         else if (m_count < CNT_MAX) m_count = m_count + 1;
         if (e.cls == 16'h8000)      m_err = 1'b1;
         else if (e.cmd == 4'b0100)  m_err = 1'b0;
         if (e.cmd == 4'b1000)       m_halted = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      chk_outputs();
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      int sel;
      r = 16'($urandom);
      sel = $urandom % 8;
      case (sel)
         0: r = 16'hF001;
         1: r = 16'hF002;
         2: r = 16'hFAAA;
         3: r = 16'hFFFF;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      rst_n_pi       = 1'b0;
      instruction_pi = '0;
      in_valid_pi    = 1'b0;
      out_ready_pi   = 1'b0;
      resume_pi      = 1'b0;
      model_reset();

      // Reset state
      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk_pi);
      @(negedge clk_pi);
      rst_n_pi = 1'b1;
      @(posedge clk_pi);
      #1;
      chk("ready_after_reset", 32'(in_ready_po), 32'd1);

      // ARITH_2OP decode and latency
      step(1'b1, 16'h1A50, 1'b1, 1'b0);
      chk("arith_class", 32'(class_po), 32'h0002);
      chk("arith_dest",  32'(dest_po),  32'd5);
      chk("arith_src1",  32'(src1_po),  32'd1);
      chk("arith_src2",  32'(src2_po),  32'd2);
      chk("arith_alu",   32'(alu_func_po), 32'd0);
      chk("arith_count", 32'(count_po), 32'd1);

      // Branch operand selection and MOVI_HI
      step(1'b1, 16'h8A40, 1'b1, 1'b0);
      chk("beq_class", 32'(class_po), 32'h0200);
      chk("beq_src1",  32'(src1_po),  32'd5);
      chk("beq_src2",  32'(src2_po),  32'd1);
      step(1'b1, 16'h3B12, 1'b1, 1'b0);
      chk("movi_class", 32'(class_po), 32'h0010);

      // Clear count, drain, then a stalled stream of four
      step(1'b1, 16'hFAAA, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      q_deliv.delete();
      step(1'b1, 16'h1200, 1'b1, 1'b0);
      step(1'b1, 16'h4400, 1'b1, 1'b0);
      step(1'b1, 16'h6600, 1'b0, 1'b0);
      step(1'b1, 16'h6600, 1'b0, 1'b0);
      step(1'b1, 16'h6600, 1'b1, 1'b0);
      step(1'b1, 16'h7800, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("stream_count", 32'(count_po), 32'd4);
      chk("stream_ndeliv", 32'(q_deliv.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < q_deliv.size()) chk("stream_order", 32'(q_deliv[i]), 32'(i + 1));
      end

      // Halt and resume
      step(1'b1, 16'hFFFF, 1'b1, 1'b0);
      chk("halt_cmd", 32'(cmd_po), 32'b1000);
      chk("halt_ready", 32'(in_ready_po), 32'd0);
      step(1'b1, 16'h1000, 1'b1, 1'b0);
      step(1'b1, 16'h1000, 1'b1, 1'b0);
      step(1'b1, 16'h1000, 1'b1, 1'b1);
      chk("resume_ready", 32'(in_ready_po), 32'd1);
      step(1'b1, 16'h1000, 1'b1, 1'b0);

      // Illegal sets err; rst command clears err and count
      step(1'b1, 16'hD000, 1'b1, 1'b0);
      chk("illegal_class", 32'(class_po), 32'h8000);
      chk("illegal_err",   32'(err_po),   32'd1);
      step(1'b1, 16'hE123, 1'b1, 1'b0);
      step(1'b1, 16'hF123, 1'b1, 1'b0);
      chk("ctl_illegal_class", 32'(class_po), 32'h8000);
      step(1'b1, 16'hFAAA, 1'b1, 1'b0);
      chk("rstcmd_err",   32'(err_po),   32'd0);
      chk("rstcmd_count", 32'(count_po), 32'd0);

      // Counter saturation
      for (int i = 0; i < CNT_MAX + 5; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
      chk("count_sat", 32'(count_po), 32'(CNT_MAX));

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, rand_instr(), ($urandom % 3) != 0, ($urandom % 3) == 0);
      end
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Asynchronous reset during a stall
      step(1'b1, 16'h1A50, 1'b0, 1'b0);
      step(1'b1, 16'h2A51, 1'b0, 1'b0);
      chk("stall_vld", 32'(out_valid_po), 32'd1);
      #3;
      rst_n_pi = 1'b0;
      #1;
      chk_zero("async_rst");
      in_valid_pi  = 1'b0;
      out_ready_pi = 1'b1;
      repeat (2) @(posedge clk_pi);
      #1;
      chk_zero("rst_held");
      @(negedge clk_pi);
      rst_n_pi = 1'b1;
      model_reset();
      @(posedge clk_pi);
      #1;
      chk("post_rst_vld",   32'(out_valid_po), 32'd0);
      chk("post_rst_ready", 32'(in_ready_po),  32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h5FC7, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 16, meaning instruction width in bits.
REQ-002 The block SHALL have parameter REG_W, default 3, meaning register-address field width; legal only when INSTR_W >= 4 + 3*REG_W + 3.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the accepted-instruction counter.
REQ-004 The block SHALL have port clk_pi, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst_n_pi, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port instruction_pi, input, INSTR_W bits: the instruction offered.
REQ-007 The block SHALL have port in_valid_pi, input, 1 bit: instruction_pi is valid.
REQ-008 The block SHALL have port in_ready_po, output, 1 bit: the stage accepts this cycle.
REQ-009 The block SHALL have port resume_pi, input, 1 bit: leave the halted state.
REQ-010 The block SHALL have port out_valid_po, output, 1 bit: decoded fields are valid.
REQ-011 The block SHALL have port out_ready_pi, input, 1 bit: the consumer takes the decoded instruction.
REQ-012 The block SHALL have port class_po, output, 16 bits: one-hot instruction class.
REQ-013 The block SHALL have port cmd_po, output, 4 bits: {halt, rst, stb, stc} control-command flags.
REQ-014 The block SHALL have port dest_po, output, REG_W bits: destination register.
REQ-015 The block SHALL have ports src1_po and src2_po, output, REG_W bits each: source registers.
REQ-016 The block SHALL have port alu_func_po, output, 3 bits: ALU function, instruction[2:0].
REQ-017 The block SHALL have port imm_po, output, INSTR_W-4 bits: immediate, instruction[INSTR_W-5:0].
REQ-018 The block SHALL have port count_po, output, CNT_W bits: count of accepted instructions.
REQ-019 The block SHALL have port err_po, output, 1 bit: sticky illegal-instruction flag.

Function
REQ-020 Opcode SHALL be instruction[INSTR_W-1:INSTR_W-4]; field A = the next REG_W bits below the opcode, field B = the REG_W bits below A, field C = the REG_W bits below B.
REQ-021 class_po bit SHALL be set by opcode as follows: 0 NOP(0000), 1 ARITH_2OP(0001), 2 ARITH_1OP(0010), 3 MOVI_LO(0011 with field-B MSB=0), 4 MOVI_HI(0011 with field-B MSB=1), 5 ADDI(0100), 6 SUBI(0101), 7 LOAD(0110), 8 STOR(0111), 9 BEQ(1000), 10 BGE(1001), 11 BLE(1010), 12 BC(1011), 13 J(1100), 14 CONTROL(1111 with a recognised command), 15 ILLEGAL; exactly one bit SHALL be set while out_valid_po=1.
REQ-022 Control commands SHALL be the low 12 bits: 0x001 stc, 0x002 stb, 0xAAA rst, 0xFFF halt (INSTR_W=16); any other value with opcode 1111 SHALL be ILLEGAL, as SHALL opcodes 1101 and 1110.
REQ-023 dest_po SHALL be field A; for branches (class bits 9-12) src1_po=A and src2_po=B, otherwise src1_po=B and src2_po=C.
REQ-024 The stage SHALL be a 1-entry registered pipeline: an instruction accepted (in_valid_pi & in_ready_po) at edge N SHALL appear on the outputs with out_valid_po=1 after edge N (latency 1).
REQ-025 in_ready_po SHALL equal (state==RUN) & (~out_valid_po | out_ready_pi); simultaneous drain and accept SHALL sustain 1 instruction/cycle.
REQ-026 While out_valid_po=1 & out_ready_pi=0, all outputs except count_po and err_po SHALL hold stable.
REQ-027 The FSM SHALL have states RUN and HALTED; accepting a halt command SHALL emit it normally and move to HALTED at the same edge.
REQ-028 In HALTED, in_ready_po SHALL be 0; resume_pi=1 SHALL return to RUN at the next edge; resume_pi in RUN SHALL be ignored.
REQ-029 count_po SHALL increment by 1 per accepted instruction, saturating at all-ones; accepting an rst command SHALL clear it to 0 instead of incrementing.
REQ-030 err_po SHALL set at the edge an ILLEGAL instruction is accepted and clear only on rst_n_pi or an accepted rst command; an ILLEGAL instruction SHALL still be emitted with class bit 15.

Reset
REQ-031 rst_n_pi low SHALL immediately force state=RUN, out_valid_po=0, class_po=0, cmd_po=0, dest/src/alu/imm=0, count_po=0, err_po=0, discarding any held instruction.
REQ-032 After rst_n_pi deasserts, in_ready_po SHALL be 1 at the first edge.

Verification
REQ-033 0x1A50 with out_ready_pi=1 -> next cycle class_po bit1, dest=5, src1=1, src2=2, alu=0, count=1.
REQ-034 BEQ 0x8A40 -> class bit9, src1=5, src2=1; MOVI 0x3B12 -> class bit4.
REQ-035 Back-to-back stream of 4 instructions with out_ready_pi low for 2 cycles in the middle -> no loss or duplication, outputs stable while stalled, count=4.
REQ-036 0xFFFF accepted -> cmd_po=1000, in_ready_po=0 until resume_pi pulse, then 1 the following cycle.
REQ-037 0xD000 -> class bit15, err_po=1; then 0xFAAA -> err_po=0, count=0.
REQ-038 rst_n_pi asserted mid-stall with out_valid_po=1 -> all outputs zero asynchronously, no output after release.
